// File: rtl/gpr_pkg.sv
// Shared types and defaults for the multi-port general-purpose register file.
// Lane extraction works on vectors up to VEC_MAX bits and lanes up to LANE_MAX bits.
package gpr_pkg;

  typedef enum logic {GPR_INIT, GPR_RUN} gpr_state_t;

  localparam int          DEF_DATA_WIDTH = 32;
  localparam int          DEF_ADDR_WIDTH = 5;
  localparam int          DEF_NUM_RD     = 2;
  localparam int          DEF_BYPASS_EN  = 1;
  localparam int          DEF_ZERO_REG   = 1;
  localparam logic [63:0] DEF_INIT_VALUE = '0;

  localparam int VEC_MAX  = 256;
  localparam int LANE_MAX = 64;

  function automatic logic [LANE_MAX-1:0] get_lane(input logic [VEC_MAX-1:0] vec,
                                                   input int unsigned         lane,
                                                   input int unsigned         width);
    logic [VEC_MAX-1:0] mask;
    mask = (VEC_MAX'(1) << width) - VEC_MAX'(1);
    return LANE_MAX'((vec >> (lane * width)) & mask);
  endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One read lane: address decode into storage, zero/bypass mux, and the
// stall-aware registered copy handed to the ALU.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYPASS_EN  = DEF_BYPASS_EN,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  reg_clk,
  input  logic                  reg_rst,
  input  logic                  stall_pipeline,
  input  logic                  force_zero,
  input  logic [DATA_WIDTH-1:0] mem [DEPTH],
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic                  wr_commit,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rs_data_r,
  output logic [DATA_WIDTH-1:0] rs_data
);

  logic [DATA_WIDTH-1:0] rs_data_d, rs_data_q;

  // Zero register and init blanking take priority over the bypass path.
  always_comb begin
    rs_data_r = mem[rs_addr];
    if ((BYPASS_EN != 0) && wr_commit && (wr_addr == rs_addr)) rs_data_r = wr_data;
    if (((ZERO_REG != 0) && (rs_addr == '0)) || force_zero) rs_data_r = '0;
  end

  always_comb begin
    rs_data_d = stall_pipeline ? rs_data_q : rs_data_r;
  end

  always_ff @(posedge reg_clk) begin
    if (reg_rst) rs_data_q <= '0;
    else         rs_data_q <= rs_data_d;
  end

  assign rs_data = rs_data_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-read-port register file with one write port and a post-reset clear sequencer.
//   state    | meaning
//   GPR_INIT | clearing entry init_cnt each edge; writes ignored, reads forced to 0
//   GPR_RUN  | normal operation; init_done high
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    NUM_RD     = DEF_NUM_RD,
  parameter int                    BYPASS_EN  = DEF_BYPASS_EN,
  parameter int                    ZERO_REG   = DEF_ZERO_REG,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEF_INIT_VALUE)
) (
  input  logic                         reg_clk,
  input  logic                         reg_rst,
  input  logic                         wr_data_en,
  input  logic [ADDR_WIDTH-1:0]        rd,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr,
  input  logic                         stall_pipeline,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data_r,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data,
  output logic                         init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  gpr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_drop;
  logic                  wr_commit;
  logic                  force_zero;

  assign wr_drop    = (ZERO_REG != 0) && (rd == '0);
  assign force_zero = (state_q == GPR_INIT);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = rd;
    mem_wdata   = wr_data;
    wr_commit   = 1'b0;
    unique case (state_q)
      GPR_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt_q;
        mem_wdata = INIT_VALUE;
        // Counter parks on the last entry; it never wraps back to 0.
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d     = GPR_RUN;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        end
      end
      GPR_RUN: begin
        wr_commit = wr_data_en && !wr_drop;
        mem_we    = wr_commit;
      end
      default: state_d = GPR_INIT;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      state_q     <= GPR_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage has no reset of its own; the init sequence is what clears it.
  always_ff @(posedge reg_clk) begin
    if (!reg_rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign init_done = init_done_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] lane_addr;

    assign lane_addr = ADDR_WIDTH'(get_lane(VEC_MAX'(rs_addr), i, ADDR_WIDTH));

    gpr_rd_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS_EN (BYPASS_EN),
      .ZERO_REG  (ZERO_REG),
      .DEPTH     (DEPTH)
    ) u_port (
      .reg_clk       (reg_clk),
      .reg_rst       (reg_rst),
      .stall_pipeline(stall_pipeline),
      .force_zero    (force_zero),
      .mem           (mem_q),
      .rs_addr       (lane_addr),
      .wr_commit     (wr_commit),
      .wr_addr       (rd),
      .wr_data       (wr_data),
      .rs_data_r     (rs_data_r[i*DATA_WIDTH +: DATA_WIDTH]),
      .rs_data       (rs_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
